// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave for the 3-byte register protocol (ID, address, data).
// Latency: 3 clk from a pin edge to its internal pulse, state/registers update 1 clk later; miso moves 4 clk after sck fall.
// Backpressure: none; the SPI master paces the frame and sck phases must be >= 6 clk.
//
// Ports:
//   clk, rst         system clock, asynchronous active-low reset
//   ss, sck, mosi    SPI pins (asynchronous to clk), sck idles low
//   miso, miso_oe    read data out (MSB first) and its drive enable
//   host_addr/rdata  registered host readback of the register bank
//   wr_pulse/addr/data  write-commit strobe with held address/data
//   rd_pulse, err_pulse  read-latch strobe and error strobe
module spi_slave_regs #(
    parameter logic [7:0] SLAVE_IDW = 8'h64,
    parameter logic [7:0] SLAVE_IDR = 8'h65,
    parameter int         NREG      = 16,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_pulse,
    output logic       err_pulse
);

    localparam int         IDXW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [8:0] NREG_W = 9'(NREG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    // Pin conditioning: [0],[1] synchronize, [2] is the history flop.
    // ss/sck history resets low so that a frame already in progress when
    // reset releases never produces an ss fall; it is ignored until ss
    // goes high and falls again.
    logic [2:0] ss_pipe_q;
    logic [2:0] sck_pipe_q;
    logic [2:0] mosi_pipe_q;

    logic ss_fall_q, ss_rise_q, sck_rise_q, sck_fall_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic       is_rd_q, is_rd_d;
    logic       oor_q, oor_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic       wr_pulse_q, wr_pulse_d;
    logic       rd_pulse_q, rd_pulse_d;
    logic       err_pulse_q, err_pulse_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] host_rdata_q, host_rdata_d;

    logic [7:0] regs_q [NREG];
    logic       reg_we;

    logic [7:0] byte_in;
    logic       byte_done;
    logic       byte_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_pipe_q   <= 3'b000;
            sck_pipe_q  <= 3'b000;
            mosi_pipe_q <= 3'b000;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
        end else begin
            ss_pipe_q   <= {ss_pipe_q[1:0], ss};
            sck_pipe_q  <= {sck_pipe_q[1:0], sck};
            mosi_pipe_q <= {mosi_pipe_q[1:0], mosi};
            ss_fall_q   <=  ss_pipe_q[2]  & ~ss_pipe_q[1];
            ss_rise_q   <= ~ss_pipe_q[2]  &  ss_pipe_q[1];
            sck_rise_q  <= ~sck_pipe_q[2] &  sck_pipe_q[1];
            sck_fall_q  <=  sck_pipe_q[2] & ~sck_pipe_q[1];
        end
    end

    // mosi_pipe_q[2] is aligned with sck_rise_q: both reflect the pins
    // as they were three clocks earlier.
    assign byte_in       = {shreg_q, mosi_pipe_q[2]};
    assign byte_in_range = ({1'b0, byte_in} < NREG_W);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        is_rd_d      = is_rd_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        wr_pulse_d   = 1'b0;
        rd_pulse_d   = 1'b0;
        err_pulse_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        reg_we       = 1'b0;
        byte_done    = 1'b0;

        // Bit collection runs in every byte-carrying state; in a read
        // DATA byte the shifted mosi bits are simply never used.
        if (sck_rise_q && (state_q == S_ID || state_q == S_ADDR || state_q == S_DATA)) begin
            shreg_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
        end

        case (state_q)
            S_IDLE: begin
                if (ss_fall_q) begin
                    state_d   = S_ID;
                    bit_cnt_d = 3'd0;
                    shreg_d   = 7'd0;
                    is_rd_d   = 1'b0;
                    oor_d     = 1'b0;
                end
            end
            S_ID: begin
                if (byte_done) begin
                    if (byte_in == SLAVE_IDW) begin
                        state_d = S_ADDR;
                        is_rd_d = 1'b0;
                    end else if (byte_in == SLAVE_IDR) begin
                        state_d = S_ADDR;
                        is_rd_d = 1'b1;
                    end else begin
                        state_d     = S_IGNORE;
                        err_pulse_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (byte_done) begin
                    state_d = S_DATA;
                    addr_d  = byte_in;
                    oor_d   = !byte_in_range;
                    if (is_rd_q) begin
                        tx_d       = byte_in_range ? regs_q[byte_in[IDXW-1:0]] : 8'h00;
                        rd_pulse_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // Falls present tx[7] so the master sees bit 7 on the
                // first data rise.
                if (sck_fall_q && is_rd_q) begin
                    miso_d    = tx_q[7];
                    tx_d      = {tx_q[6:0], 1'b0};
                    miso_oe_d = 1'b1;
                end
                if (byte_done) begin
                    state_d = S_IGNORE;
                    if (is_rd_q) begin
                        err_pulse_d = oor_q;
                    end else if (!oor_q) begin
                        reg_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = byte_in;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end
            end
            S_IGNORE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ss rise wins over everything else but lets a DATA byte that
        // completes on the same cycle commit first.
        if (ss_rise_q) begin
            state_d   = S_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            if (state_q == S_ID || state_q == S_ADDR || (state_q == S_DATA && !byte_done)) begin
                err_pulse_d = 1'b1;
            end
        end
    end

    // Host readback samples the bank before this cycle's commit, so a
    // same-address write shows up one clock later.
    always_comb begin
        host_rdata_d = 8'h00;
        if ({1'b0, host_addr} < NREG_W) begin
            host_rdata_d = regs_q[host_addr[IDXW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            is_rd_q      <= 1'b0;
            oor_q        <= 1'b0;
            addr_q       <= 8'h00;
            tx_q         <= 8'h00;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            wr_pulse_q   <= 1'b0;
            rd_pulse_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
            wr_addr_q    <= 8'h00;
            wr_data_q    <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            is_rd_q      <= is_rd_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            wr_pulse_q   <= wr_pulse_d;
            rd_pulse_q   <= rd_pulse_d;
            err_pulse_q  <= err_pulse_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else if (reg_we) begin
            regs_q[addr_q[IDXW-1:0]] <= byte_in;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign host_rdata = host_rdata_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_pulse   = rd_pulse_q;
    assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: directed SPI master stimulus against a frame-level model of the register slave.
// Latency: frames are paced by the bench master; results are compared after each frame settles.
// Backpressure: none; the bench drives sck with fixed half periods of at least 6 clk.
module tb_spi_slave_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_pulse;
    logic       err_pulse;

    int nchk = 0;
    int nerr = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;

    // Frame-level model: register contents plus expected commits in order.
    logic [7:0]  mdl [16];
    logic [15:0] exp_q [$];

    spi_slave_regs #(
        .SLAVE_IDW (8'h64),
        .SLAVE_IDR (8'h65),
        .NREG      (16),
        .RST_VAL   (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_pulse   (rd_pulse),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mdl_read(input logic [7:0] a);
        return (a < 8'd16) ? mdl[a[3:0]] : 8'h00;
    endfunction

    // Per-cycle monitor: miso must be 0 when not driven, and every commit
    // must match the next one the model predicted.
    always @(negedge clk) begin
        if (rst) begin
            if (!miso_oe) begin
                nchk++;
                if (miso !== 1'b0) begin
                    nerr++;
                    $display("FAIL miso_idle: got %b expected 0", miso);
                end
            end
            if (wr_pulse) begin
                wr_cnt++;
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL wr_unexpected: got %h/%h expected no commit", wr_addr, wr_data);
                end else if ({wr_addr, wr_data} !== exp_q[0]) begin
                    nerr++;
                    $display("FAIL wr_commit: got %h expected %h", {wr_addr, wr_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (rd_pulse)  rd_cnt++;
            if (err_pulse) err_cnt++;
        end
    end

    task automatic send_bit(input logic b, input int half, output logic m, output logic oe);
        mosi = b;
        repeat (half) @(negedge clk);
        m  = miso;
        oe = miso_oe;
        sck = 1'b1;
        repeat (half) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic host_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        repeat (2) @(negedge clk);
        check(name, host_rdata, exp);
    endtask

    // Drives nbits of {id,addr,data} and checks the frame outcome against
    // the protocol rules applied to the model.
    task automatic run_frame(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, input int half, output logic [7:0] rdata);
        logic [23:0] bits;
        logic        valid_id, is_rd, inr, full, addr_done, m, oe;
        int          e_wr, e_rd, e_err, e_oe, oe_n, w0, r0, x0;
        logic [7:0]  e_rdata;
        bits      = {id, addr, data};
        valid_id  = (id == 8'h64) || (id == 8'h65);
        is_rd     = (id == 8'h65);
        inr       = (addr < 8'd16);
        full      = (nbits >= 24);
        addr_done = (nbits >= 16);
        e_wr = 0; e_rd = 0; e_err = 0; e_oe = 0; oe_n = 0;
        e_rdata = 8'h00;
        rdata   = 8'h00;
        if (!valid_id) begin
            e_err = 1;
        end else begin
            if (is_rd && addr_done) begin
                e_rd    = 1;
                e_rdata = mdl_read(addr);
                e_oe    = nbits - 16;
            end
            if (!full)           e_err = 1;
            else if (is_rd)      e_err = inr ? 0 : 1;
            else if (inr)        e_wr  = 1;
            else                 e_err = 1;
        end
        if (e_wr == 1) exp_q.push_back({addr, data});
        w0 = wr_cnt; r0 = rd_cnt; x0 = err_cnt;

        ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[23-i], half, m, oe);
            if (i >= 16) begin
                rdata = {rdata[6:0], m};
                if (oe) oe_n++;
            end else if (oe) begin
                oe_n += 100;
            end
        end
        repeat (half) @(negedge clk);
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (16) @(negedge clk);

        check("frame_wr_pulses", wr_cnt - w0, e_wr);
        check("frame_rd_pulses", rd_cnt - r0, e_rd);
        check("frame_err_pulses", err_cnt - x0, e_err);
        check("frame_oe_rises", oe_n, e_oe);
        check("frame_commits_left", exp_q.size(), 0);
        if (e_rd == 1 && full) check("frame_rdata", rdata, e_rdata);
        if (e_wr == 1) mdl[addr[3:0]] = data;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_miso_oe"}, miso_oe, 0);
        check({tag, "_host_rdata"}, host_rdata, 0);
        check({tag, "_wr_pulse"}, wr_pulse, 0);
        check({tag, "_rd_pulse"}, rd_pulse, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       m, oe;
        int         w0, r0, x0;
        logic [23:0] fb;

        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; host_addr = 8'h00;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        host_check("reset_reg0", 8'h00, 8'h00);

        // Write 0xA5 to reg 3, then read it back over SPI and host port.
        run_frame(8'h64, 8'h03, 8'hA5, 24, 8, rd);
        check("wr_addr_held", wr_addr, 8'h03);
        check("wr_data_held", wr_data, 8'hA5);
        host_check("host_reg3_after_write", 8'h03, 8'hA5);
        run_frame(8'h65, 8'h03, 8'h00, 24, 8, rd);
        check("spi_read_reg3", rd, 8'hA5);

        // Wrong ID: nothing written, error flagged.
        run_frame(8'h42, 8'h03, 8'hFF, 24, 8, rd);
        host_check("host_reg3_after_bad_id", 8'h03, 8'hA5);

        // Out-of-range write and read.
        run_frame(8'h64, 8'h20, 8'h55, 24, 8, rd);
        run_frame(8'h65, 8'h20, 8'hEE, 24, 8, rd);
        check("spi_read_oor", rd, 8'h00);
        for (int i = 0; i < 16; i++) host_check("host_bank_scan1", 8'(i), mdl[i]);

        // Abort after 4 data bits, then a full write to the same address.
        run_frame(8'h64, 8'h05, 8'hFF, 20, 8, rd);
        host_check("host_reg5_after_abort", 8'h05, 8'h00);
        run_frame(8'h64, 8'h05, 8'h3C, 24, 8, rd);
        host_check("host_reg5_after_write", 8'h05, 8'h3C);
        check("wr_data_3c", wr_data, 8'h3C);

        // Reset asserted in the middle of the ADDR byte; the rest of the
        // frame must be ignored.
        host_addr = 8'h03;
        w0 = wr_cnt; r0 = rd_cnt; x0 = err_cnt;
        fb = {8'h64, 8'h03, 8'h77};
        ss = 1'b0;
        for (int i = 0; i < 11; i++) send_bit(fb[23-i], 8, m, oe);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("midreset");
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        exp_q.delete();
        rst = 1'b1;
        for (int i = 11; i < 24; i++) send_bit(fb[23-i], 8, m, oe);
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (16) @(negedge clk);
        check("midreset_wr_pulses", wr_cnt - w0, 0);
        check("midreset_rd_pulses", rd_cnt - r0, 0);
        check("midreset_err_pulses", err_cnt - x0, 0);
        host_check("host_reg3_after_reset", 8'h03, 8'h00);
        host_check("host_reg5_after_reset", 8'h05, 8'h00);

        // Back-to-back write and read at the fastest legal sck.
        run_frame(8'h64, 8'h0F, 8'h81, 24, 6, rd);
        run_frame(8'h65, 8'h0F, 8'h00, 24, 6, rd);
        check("spi_read_reg15_fast", rd, 8'h81);
        for (int i = 0; i < 16; i++) host_check("host_bank_scan2", 8'(i), mdl[i]);
        host_check("host_oor_addr", 8'h20, 8'h00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
